// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the mem_master burst engine.
//   MEM_ADDR_W / MEM_DATA_W : word address and data widths of the memory port
//   RAM_ADDR_W              : address bits actually backed by RAM; higher
//                             address bits must be zero when bounds checking
//                             (MEM_MASTER_BOUNDS_CHECK_EN) is enabled
//   MAX_BURST               : maximum beats per burst (req_len + 1)
//   MEM_RD_LAT              : memory read latency in cycles
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_ADDR_W = 24;
  localparam int MEM_DATA_W = 24;
  localparam int RAM_ADDR_W = 18;
  localparam int MAX_BURST  = 16;
  localparam int MEM_RD_LAT = 1;

  localparam int BEAT_W = $clog2(MAX_BURST);
  localparam int LAT_W  = $clog2(MEM_RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } mem_state_t;

  // High when the word address lies above the RAM-backed region.
  function automatic logic addr_out_of_range(input logic [MEM_ADDR_W-1:0] addr);
    return |addr[MEM_ADDR_W-1:RAM_ADDR_W];
  endfunction

endpackage

// File: rtl/mem_burst_ctr.sv
// -----------------------------------------------------------------------------
// mem_burst_ctr
// Address and beat counter for one burst.
//   clk, rst_n  : clock, asynchronous active-low reset (counters clear to 0)
//   load        : start of burst; loads load_addr and load_len
//   load_addr   : word address of the first beat
//   load_len    : beats - 1
//   step        : current beat completed; advance address, consume one beat
//   addr        : address of the current beat (wraps modulo 2^MEM_ADDR_W)
//   last        : current beat is the final beat of the burst
// -----------------------------------------------------------------------------
module mem_burst_ctr
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [MEM_ADDR_W-1:0] load_addr,
  input  logic [BEAT_W-1:0]     load_len,
  input  logic                  step,
  output logic [MEM_ADDR_W-1:0] addr,
  output logic                  last
);

  logic [BEAT_W-1:0] beats;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      beats <= '0;
    end else if (load) begin
      addr  <= load_addr;
      beats <= load_len;
    end else if (step) begin
      addr <= addr + MEM_ADDR_W'(1);
      if (beats != '0) begin
        beats <= beats - BEAT_W'(1);
      end
    end
  end

  assign last = (beats == '0);

endmodule

// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
// Burst master bridging a request/write/read stream interface onto a simple
// single-port data memory (1-cycle read latency).
//
// Optional feature: define MEM_MASTER_BOUNDS_CHECK_EN to enable address bounds
// checking. Beats whose address is above the RAM_ADDR_W region then issue no
// memory strobe, reads of them return 0, and the sticky err output is set
// until the next request is accepted. Without the macro, err does not exist.
//
// Ports
//   clk, rst_n                         : clock, asynchronous active-low reset
//   req_valid/req_ready                : burst request handshake
//   req_write, req_addr, req_len       : direction (1=write), start address,
//                                        beats-1
//   wr_valid/wr_ready/wr_data          : write-beat stream (into master)
//   rd_valid/rd_ready/rd_data          : read-beat stream (out of master)
//   busy                               : high whenever not IDLE
//   mem_address, mem_writedata         : registered memory address / data
//   mem_writeenable, mem_read          : one-cycle write / read strobes
//   mem_data                           : memory read data
//   err (bounds-check build only)      : sticky out-of-range error
// -----------------------------------------------------------------------------
module mem_master
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [MEM_ADDR_W-1:0] req_addr,
  input  logic [BEAT_W-1:0]     req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [MEM_DATA_W-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [MEM_DATA_W-1:0] rd_data,
  output logic                  busy,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [MEM_DATA_W-1:0] mem_writedata,
  output logic                  mem_writeenable,
  output logic                  mem_read,
  input  logic [MEM_DATA_W-1:0] mem_data
`ifdef MEM_MASTER_BOUNDS_CHECK_EN
  ,
  output logic                  err
`endif
);

  mem_state_t            state;
  logic [LAT_W-1:0]      lat_cnt;
  logic                  accept;
  logic                  step;
  logic                  last;
  logic                  oob;
  logic [MEM_ADDR_W-1:0] addr;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign step   = ((state == WR)      && wr_valid && wr_ready) ||
                  ((state == RD_DATA) && rd_valid && rd_ready);

`ifdef MEM_MASTER_BOUNDS_CHECK_EN
  assign oob = addr_out_of_range(addr);
`else
  assign oob = 1'b0;
`endif

  mem_burst_ctr u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_addr (req_addr),
    .load_len  (req_len),
    .step      (step),
    .addr      (addr),
    .last      (last)
  );

  // Burst direction is carried by the state itself (WR vs RD_*), so no
  // separate direction register is kept. req_ready/wr_ready/busy are
  // registered from the next-state decision so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_ready       <= 1'b0;
      wr_ready        <= 1'b0;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
      busy            <= 1'b0;
      mem_address     <= '0;
      mem_writedata   <= '0;
      mem_writeenable <= 1'b0;
      mem_read        <= 1'b0;
      lat_cnt         <= '0;
`ifdef MEM_MASTER_BOUNDS_CHECK_EN
      err             <= 1'b0;
`endif
    end else begin
      mem_writeenable <= 1'b0;
      mem_read        <= 1'b0;

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef MEM_MASTER_BOUNDS_CHECK_EN
            err       <= 1'b0;
`endif
            if (req_write) begin
              state    <= WR;
              wr_ready <= 1'b1;
            end else begin
              state    <= RD_ADDR;
            end
          end
        end

        WR: begin
          if (wr_valid && wr_ready) begin
            mem_address     <= addr;
            mem_writedata   <= wr_data;
            mem_writeenable <= !oob;
`ifdef MEM_MASTER_BOUNDS_CHECK_EN
            err             <= err | oob;
`endif
            if (last) begin
              state     <= IDLE;
              wr_ready  <= 1'b0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end
          end
        end

        RD_ADDR: begin
          mem_address <= addr;
          mem_read    <= !oob;
          lat_cnt     <= LAT_W'(MEM_RD_LAT);
          state       <= RD_DATA;
`ifdef MEM_MASTER_BOUNDS_CHECK_EN
          err         <= err | oob;
`endif
        end

        RD_DATA: begin
          if (!rd_valid) begin
            // Strobe cycle first, then MEM_RD_LAT cycles until mem_data
            // reflects the presented address.
            if (lat_cnt == '0) begin
              rd_valid <= 1'b1;
              rd_data  <= oob ? '0 : mem_data;
            end else begin
              lat_cnt <= lat_cnt - LAT_W'(1);
            end
          end else if (rd_ready) begin
            rd_valid <= 1'b0;
            if (last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              state <= RD_ADDR;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL: clk  in  1  system clock; all state on posedge.
REQ-002 SHALL: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: req_valid/req_ready  in/out  1/1  burst request handshake; a request is accepted when both are high.
REQ-004 SHALL: req_write  in  1  burst direction: 1 = write, 0 = read.
REQ-005 SHALL: req_addr  in  24  word address of the first beat.
REQ-006 SHALL: req_len  in  4  burst length; beats = req_len+1 (1..16).
REQ-007 SHALL: wr_valid/wr_ready/wr_data  in/out/in  1/1/24  write-beat stream.
REQ-008 SHALL: rd_valid/rd_ready/rd_data  out/in/out  1/1/24  read-beat stream.
REQ-009 SHALL: busy  out  1  high whenever state is not IDLE.
REQ-010 SHALL: err  out  1  sticky bounds error; present only under the macro in REQ-026.
REQ-011 SHALL: mem_address/mem_writedata  out/out  24/24  data-memory address and write data, both registered.
REQ-012 SHALL: mem_writeenable/mem_read/mem_data  out/out/in  1/1/24  memory write strobe, read strobe, and read data.

Function
REQ-013 SHALL: FSM states are IDLE, WR, RD_ADDR, RD_DATA.
- IDLE -> WR on an accepted request with req_write=1.
- IDLE -> RD_ADDR on an accepted request with req_write=0.
REQ-014 SHALL: req_ready=1 only in IDLE; req_valid in any other state is ignored.
REQ-015 SHALL: on acceptance, latch req_addr into the address counter, load the beat counter with req_len, and latch req_write.
REQ-016 SHALL: in WR, wr_ready=1.
- Each wr_valid&wr_ready beat registers mem_address=counter, mem_writedata=wr_data, and mem_writeenable=1 for exactly the next cycle.
REQ-017 SHALL: after the last write beat is accepted, go to IDLE; mem_writeenable pulses in the first IDLE cycle.
REQ-018 SHALL: RD_ADDR lasts one cycle and drives mem_address=counter with mem_read=1 for exactly the next cycle (memory read latency is 1 cycle).
REQ-019 SHALL: in RD_DATA, capture mem_data into rd_data on entry and hold rd_valid=1 with rd_data stable until rd_ready.
REQ-020 SHALL: on rd_valid&rd_ready, go to RD_ADDR if beats remain, else go to IDLE with rd_valid=0 next cycle.
REQ-021 SHALL: the address counter increments by 1 per beat, modulo 2^24 (0xFFFFFF wraps to 0x000000).
REQ-022 SHALL: mem_writeenable and mem_read are never high in the same cycle; each is low in every cycle not specified above.

Reset
REQ-023 SHALL: while rst_n=0 (asynchronously), state=IDLE and every output =0.
- Exception: req_ready=1 one cycle after rst_n is released.
REQ-024 SHALL: reset mid-burst aborts the burst: no further mem_writeenable/mem_read pulses and no rd_valid.
REQ-025 SHALL: the address and beat counters reset to 0.

Configuration
REQ-026 SHALL: with MEM_MASTER_BOUNDS_CHECK_EN defined, a beat whose address[23:18]!=0 behaves as follows:
- no mem_writeenable/mem_read pulse is issued for it;
- a read beat returns rd_data=0;
- err is set and stays set until the next request acceptance clears it;
- the handshake timing is unchanged.
REQ-027 SHALL: without MEM_MASTER_BOUNDS_CHECK_EN, the err port is absent and all addresses pass through unchecked.

Structure
REQ-028 SHALL: mem_pkg holds the state enum and the constants MEM_ADDR_W=24, MEM_DATA_W=24, RAM_ADDR_W=18, MAX_BURST=16, MEM_RD_LAT=1.
REQ-029 SHALL: the address and beat counting (load, increment, last-beat flag) lives in a sub-module mem_burst_ctr.

Verification
REQ-030 SHALL: single write, addr=0x000010, len=0, data=0xABCD
- -> one mem_writeenable pulse with mem_address=0x000010 and mem_writedata=0xABCD; busy falls 1 cycle after the wr beat.
REQ-031 SHALL: 4-beat read at addr=0x000100, memory model returns addr+5, rd_ready=1
- -> rd_data = 0x105, 0x106, 0x107, 0x108; mem_read pulses exactly 4 times.
REQ-032 SHALL: read with rd_ready held low 5 cycles on beat 2
- -> rd_data is stable and no extra mem_read pulses occur during the stall.
REQ-033 SHALL: 3-beat write from 0xFFFFFF
- -> mem_address sequence 0xFFFFFF, 0x000000, 0x000001.
REQ-034 SHALL: rst_n pulled low during beat 2 of an 8-beat write
- -> mem_writeenable drops immediately, busy=0, and req_ready=1 after release.
REQ-035 SHALL: with MEM_MASTER_BOUNDS_CHECK_EN, read at 0x040000
- -> no mem_read pulse, rd_data=0, err=1; the next request acceptance clears err.
